knap_search: RTL and testbench
==============================

KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 SHALL have parameter N_ITEMS, default 17: number of selectable items, i.e. the width of the candidate vector.
REQ-002 SHALL have parameter CNT_W, default N_ITEMS+1: width of the hit counter, so that all 2^N_ITEMS hits fit.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: request a full enumeration; sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1: terminate the scan in progress.
REQ-007 SHALL have port sel, output, N_ITEMS: candidate selection vector driven to the downstream validity checker; bit i is item i (bit 0 is item A).
REQ-008 SHALL have port valid_in, input, 1: combinational validity verdict from the checker for the current sel.
REQ-009 SHALL have port busy, output, 1: high while in SCAN.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a scan ends, whether completed or aborted.
REQ-011 SHALL have port aborted, output, 1: high when the last scan ended by abort; held until the next start.
REQ-012 SHALL have port hit_count, output, CNT_W: number of candidates for which valid_in was high.
REQ-013 SHALL have port first_found, output, 1: at least one hit recorded.
REQ-014 SHALL have port first_sel, output, N_ITEMS: lowest-numbered hit vector.
REQ-015 SHALL have port last_sel, output, N_ITEMS: highest-numbered hit vector.

Function
REQ-016 SHALL implement a three-state FSM (IDLE, SCAN, FIN) with transitions IDLE->SCAN on start, SCAN->FIN on terminal candidate or abort, and FIN->IDLE unconditionally after one cycle.
REQ-017 SHALL, on IDLE->SCAN, clear hit_count, first_found, first_sel, last_sel and aborted, and load sel with 0.
REQ-018 SHALL evaluate exactly one candidate per SCAN cycle: valid_in is sampled in the same cycle sel is presented (zero-latency checker), then sel increments by 1.
REQ-019 SHALL, on a sampled hit, increment hit_count by 1 and set last_sel to sel; if first_found was 0, it SHALL also set first_sel to sel and first_found to 1.
REQ-020 SHALL evaluate the candidate with all N_ITEMS bits set, then enter FIN without wrapping sel; a full scan lasts exactly 2^N_ITEMS SCAN cycles.
REQ-021 SHALL, when abort is high in SCAN, still evaluate the current candidate, then enter FIN with aborted=1.
REQ-022 SHALL make abort take precedence over normal completion; aborted SHALL be 1 if abort coincides with the terminal candidate.
REQ-023 SHALL assert done for exactly the FIN cycle; results SHALL remain stable from FIN until the next accepted start.
REQ-024 SHALL ignore start while in SCAN or FIN, and SHALL ignore abort while in IDLE or FIN.
REQ-025 SHALL hold sel at its last value in IDLE and FIN; the checker verdict is then don't-care.
REQ-026 SHALL prevent hit_count from overflowing, given the CNT_W default of N_ITEMS+1; no saturation logic is required.

Reset
REQ-027 SHALL, on rst_n low and regardless of clk, force state=IDLE, sel=0, busy=0, done=0, aborted=0, hit_count=0, first_found=0, first_sel=0 and last_sel=0.
REQ-028 SHALL, on reset during SCAN, discard the scan with no done pulse; operation resumes on the first start after rst_n rises.

Configuration
REQ-029 SHALL provide macro KNAP_FIRST_HIT_EN; when defined, the first hit SHALL also end the scan, entering FIN the following cycle with hit_count=1 and first_sel=last_sel=the hit vector.
REQ-030 SHALL, when KNAP_FIRST_HIT_EN is undefined, always scan the full space per REQ-020.
REQ-031 SHALL, under KNAP_FIRST_HIT_EN, keep aborted=0 for a first-hit stop, and SHALL treat an abort in the same cycle as the first hit per REQ-022.

Verification
REQ-032 SHALL cover: stub valid_in=(sel==17'h00005), pulse start -> 131072 busy cycles, done pulse, hit_count=1, first_sel=last_sel=17'h00005, aborted=0.
REQ-033 SHALL cover: valid_in tied 1 -> hit_count=18'h20000, first_sel=0, last_sel=17'h1FFFF, first_found=1.
REQ-034 SHALL cover: valid_in tied 0 -> hit_count=0, first_found=0, done after 131072 SCAN cycles.
REQ-035 SHALL cover: valid_in=sel[0], abort asserted on the 100th SCAN cycle (sel=99) -> aborted=1, hit_count=50, last_sel=99, done on the next cycle.
REQ-036 SHALL cover: rst_n pulsed low at SCAN cycle 500 -> all outputs 0 immediately and no done; a subsequent start runs a clean full scan; start pulses during SCAN are ignored.
REQ-037 SHALL cover, with KNAP_FIRST_HIT_EN: stub hits at sel=7 and sel=9 -> stop after 8 SCAN cycles, hit_count=1, first_sel=7.

Source files
------------

// File: rtl/knap_search.sv
// Exhaustive subset enumerator: walks sel from 0 to all-ones, one candidate per cycle,
// tallying checker hits. Optional macro KNAP_FIRST_HIT_EN stops the scan on the first hit.
module knap_search #(
  parameter int N_ITEMS = 17,
  parameter int CNT_W   = N_ITEMS + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [N_ITEMS-1:0] sel,
  input  logic               valid_in,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   hit_count,
  output logic               first_found,
  output logic [N_ITEMS-1:0] first_sel,
  output logic [N_ITEMS-1:0] last_sel
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_e;

  state_e             state_q, state_d;
  logic [N_ITEMS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [N_ITEMS-1:0] first_q, first_d;
  logic [N_ITEMS-1:0] last_q, last_d;
  logic               aborted_q, aborted_d;
  logic               stop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      first_q   <= '0;
      last_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      first_q   <= first_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    first_d   = first_q;
    last_d    = last_q;
    aborted_d = aborted_q;
`ifdef KNAP_FIRST_HIT_EN
    stop_hit  = valid_in && !found_q;
`else
    stop_hit  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          sel_d     = '0;
          cnt_d     = '0;
          found_d   = 1'b0;
          first_d   = '0;
          last_d    = '0;
          aborted_d = 1'b0;
        end
      end
      SCAN: begin
        if (valid_in) begin
          cnt_d  = cnt_q + CNT_W'(1);
          last_d = sel_q;
          if (!found_q) begin
            first_d = sel_q;
            found_d = 1'b1;
          end
        end
        // The candidate under evaluation is always counted; sel then freezes on exit.
        if (abort) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end else if ((&sel_q) || stop_hit) begin
          state_d = FIN;
        end else begin
          sel_d = sel_q + N_ITEMS'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel         = sel_q;
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == FIN);
  assign aborted     = aborted_q;
  assign hit_count   = cnt_q;
  assign first_found = found_q;
  assign first_sel   = first_q;
  assign last_sel    = last_q;

endmodule

// File: tb/tb_knap_search.sv
// Directed bench for knap_search with a 12-item instance and a stub validity checker.
module tb_knap_search;

  localparam int N = 12;
  localparam int C = N + 1;
  localparam int FULL = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, valid_in;
  logic [N-1:0] sel, first_sel, last_sel;
  logic         busy, done, aborted, first_found;
  logic [C-1:0] hit_count;
  int           mode;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    int mode;
    int abort_at;
    int cycles;
    int hits;
    int first;
    int last;
    int found;
    int ab;
  } vec_t;

  vec_t tbl [6];

  knap_search #(.N_ITEMS(N), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
    .valid_in(valid_in), .busy(busy), .done(done), .aborted(aborted),
    .hit_count(hit_count), .first_found(first_found),
    .first_sel(first_sel), .last_sel(last_sel)
  );

  always #5 clk = ~clk;

  always_comb begin
    valid_in = 1'b0;
    case (mode)
      0: valid_in = (sel == N'(5));
      1: valid_in = 1'b1;
      2: valid_in = 1'b0;
      3: valid_in = sel[0];
      4: valid_in = (sel == N'(7)) || (sel == N'(9));
      default: valid_in = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int cyc;
    int cnt_hold;
    mode = v.mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy) begin
      cyc++;
      if (cyc == 1) chk($sformatf("r%0d_sel_start", idx), sel, 0);
      abort = (v.abort_at != 0) && (cyc == v.abort_at);
      start = (cyc == 3);
      @(negedge clk);
      if (cyc > FULL + 100) break;
    end
    abort = 1'b0;
    start = 1'b0;
    chk($sformatf("r%0d_scan_cycles", idx), cyc, v.cycles);
    chk($sformatf("r%0d_done_fin", idx), done, 1);
    chk($sformatf("r%0d_aborted", idx), aborted, v.ab);
    chk($sformatf("r%0d_hit_count", idx), hit_count, v.hits);
    chk($sformatf("r%0d_first_found", idx), first_found, v.found);
    chk($sformatf("r%0d_first_sel", idx), first_sel, v.first);
    chk($sformatf("r%0d_last_sel", idx), last_sel, v.last);
    cnt_hold = int'(hit_count);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk($sformatf("r%0d_done_one_cycle", idx), done, 0);
    chk($sformatf("r%0d_results_hold", idx), hit_count, cnt_hold);
    chk($sformatf("r%0d_aborted_hold", idx), aborted, v.ab);
  endtask

  initial begin
    int cyc;
    int saw_done;
`ifdef KNAP_FIRST_HIT_EN
    tbl[0] = '{0, 0, 6, 1, 5, 5, 1, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 0, 1, 0};
    tbl[2] = '{2, 0, FULL, 0, 0, 0, 0, 0};
    tbl[3] = '{3, 100, 2, 1, 1, 1, 1, 0};
    tbl[4] = '{4, 0, 8, 1, 7, 7, 1, 0};
    tbl[5] = '{1, 1, 1, 1, 0, 0, 1, 1};
`else
    tbl[0] = '{0, 0, FULL, 1, 5, 5, 1, 0};
    tbl[1] = '{1, 0, FULL, FULL, 0, FULL - 1, 1, 0};
    tbl[2] = '{2, 0, FULL, 0, 0, 0, 0, 0};
    tbl[3] = '{3, 100, 100, 50, 1, 99, 1, 1};
    tbl[4] = '{4, 0, FULL, 2, 7, 9, 1, 0};
    tbl[5] = '{1, FULL, FULL, FULL, 0, FULL - 1, 1, 1};
`endif
    mode  = 2;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sel, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_found", first_found, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-scan: outputs clear at once, no done pulse, then a clean restart.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached_500", cyc, 500);
    chk("mid_sel_before_rst", sel, 499);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_aborted", aborted, 0);
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("mid_no_done_after_rst", saw_done, 0);

    for (int i = 0; i < 6; i++) run_row(tbl[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
